// File: rtl/mac_adder_tree.sv
// Pipelined signed adder tree: reduces N_IN masked MAC lanes to one WID-bit sum per cycle.
// Optional macro ADDER_TREE_SAT_EN selects saturation instead of wrap-around on the final sum.
module mac_adder_tree #(
  parameter int N_IN = 32,
  parameter int WID  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [WID-1:0] output_mac [N_IN],
  input  logic [N_IN-1:0]       mac_enable,
  input  logic                  adder_enable,
  output logic signed [WID-1:0] adder_tree_out,
  output logic                  adder_tree_valid
);

  localparam int LEVELS = $clog2(N_IN);
  localparam int NP     = 2 ** LEVELS;
  localparam int SW     = WID + LEVELS;

  // Every tree node, all levels, in one flat array sign-extended to full width.
  // Level k occupies indices [2*NP - 2^(LEVELS-k+1) +: 2^(LEVELS-k)]; the root is the last entry.
  logic signed [SW-1:0] node [2*NP-1];

  for (genvar i = 0; i < NP; i++) begin : g_lane
    if (i < N_IN) begin : g_real
      assign node[i] = (adder_enable && mac_enable[i]) ? SW'(output_mac[i]) : '0;
    end else begin : g_pad
      assign node[i] = '0;
    end
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int W  = WID + k;
    localparam int NN = 2 ** (LEVELS - k);
    localparam int IB = 2 * NP - 2 ** (LEVELS - k + 2);
    localparam int OB = 2 * NP - 2 ** (LEVELS - k + 1);

    logic signed [W-1:0] sum_d [NN];
    logic signed [W-1:0] sum_q [NN];

    // Children fit in W-1 bits, so narrowing them to W bits before adding loses nothing.
    always_comb begin
      for (int j = 0; j < NN; j++) begin
        sum_d[j] = W'(node[IB + 2*j]) + W'(node[IB + 2*j + 1]);
      end
    end

    // NOTE: these are pipeline registers, not a memory, so each one is reset; an in-flight
    // partial sum must never survive a reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j < NN; j++) sum_q[j] <= '0;
      end else begin
        // NOTE: state is updated with <= so every level samples the previous level's old value.
        sum_q <= sum_d;
      end
    end

    for (genvar j = 0; j < NN; j++) begin : g_node
      assign node[OB + j] = SW'(sum_q[j]);
    end
  end

  logic [LEVELS-1:0] valid_d, valid_q;

  always_comb begin
    valid_d = LEVELS'({valid_q, adder_enable});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  assign adder_tree_valid = valid_q[LEVELS-1];

`ifdef ADDER_TREE_SAT_EN
  localparam logic signed [SW-1:0] SAT_MAX = {{(LEVELS+1){1'b0}}, {(WID-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(LEVELS+1){1'b1}}, {(WID-1){1'b0}}};

  // NOTE: every branch assigns adder_tree_out, so no latch is inferred.
  always_comb begin
    if (node[2*NP-2] > SAT_MAX)      adder_tree_out = SAT_MAX[WID-1:0];
    else if (node[2*NP-2] < SAT_MIN) adder_tree_out = SAT_MIN[WID-1:0];
    else                             adder_tree_out = WID'(node[2*NP-2]);
  end
`else
  // Wrap-around keeps the low WID bits, consistent with the rest of the PE datapath.
  always_comb begin
    adder_tree_out = WID'(node[2*NP-2]);
  end
`endif

endmodule

// File: tb/tb_mac_adder_tree.sv
// Scoreboard bench for mac_adder_tree (N_IN=32, WID=16, five-cycle latency).
// Honours ADDER_TREE_SAT_EN for the expected overflow results.
module tb_mac_adder_tree;

  localparam int N_IN   = 32;
  localparam int WID    = 16;
  localparam int LEVELS = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic signed [WID-1:0] output_mac [N_IN];
  logic [N_IN-1:0]       mac_enable;
  logic                  adder_enable;
  logic signed [WID-1:0] adder_tree_out;
  logic                  adder_tree_valid;

  mac_adder_tree #(.N_IN(N_IN), .WID(WID)) dut (
    .clk              (clk),
    .rst              (rst),
    .output_mac       (output_mac),
    .mac_enable       (mac_enable),
    .adder_enable     (adder_enable),
    .adder_tree_out   (adder_tree_out),
    .adder_tree_valid (adder_tree_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WID-1:0] out;
    logic           vld;
  } exp_t;

  exp_t  exp_q [$];
  string tag_q [$];
  int    n_tests = 0;
  int    n_fail  = 0;

  logic signed [WID-1:0] lanes [N_IN];

  task automatic check(input string tag, input logic [WID-1:0] got, input logic [WID-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [WID-1:0] convert(input longint s);
    longint r;
    r = s;
`ifdef ADDER_TREE_SAT_EN
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[WID-1:0];
  endfunction

  task automatic prime(input string tag);
    exp_t e;
    exp_q.delete();
    tag_q.delete();
    e.out = '0;
    e.vld = 1'b0;
    for (int i = 0; i < LEVELS; i++) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
  endtask

  // One cycle: retire the oldest expectation, then drive a new vector and queue its result.
  task automatic step(input string tag, input logic en, input logic [N_IN-1:0] mask);
    exp_t   e;
    string  t;
    longint s;
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, "_out"}, adder_tree_out, e.out);
    check({t, "_vld"}, {{(WID-1){1'b0}}, adder_tree_valid}, {{(WID-1){1'b0}}, e.vld});
    output_mac   = lanes;
    mac_enable   = mask;
    adder_enable = en;
    s = 0;
    for (int i = 0; i < N_IN; i++) if (en && mask[i]) s += longint'(lanes[i]);
    e.out = convert(s);
    e.vld = en;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b0, '0);
  endtask

  task automatic fill(input logic signed [WID-1:0] v);
    for (int i = 0; i < N_IN; i++) lanes[i] = v;
  endtask

  initial begin
    logic [7:0] en_pat;
    rst          = 1'b1;
    adder_enable = 1'b0;
    mac_enable   = '0;
    fill('0);
    output_mac   = lanes;
    #1;
    check("reset_out", adder_tree_out, '0);
    check("reset_vld", {{(WID-1){1'b0}}, adder_tree_valid}, '0);
    @(negedge clk);
    rst = 1'b0;
    prime("start");

    fill(16'sd1);
    step("sum_all", 1'b1, '1);
    idle(3);

    for (int i = 0; i < N_IN; i++) lanes[i] = WID'(i + 1);
    step("mask_lsb", 1'b1, 32'h0000_0001);
    step("mask_msb", 1'b1, 32'h8000_0000);
    step("mask_mid", 1'b1, 32'h0000_F00F);
    step("en_low",   1'b0, '1);

    for (int i = 0; i < N_IN; i++) lanes[i] = (i % 2 == 0) ? 16'sd100 : -16'sd100;
    step("alt_pm100", 1'b1, '1);
    step("alt_odd",   1'b1, 32'h5555_5555);
    fill(-16'sd3);
    step("neg3", 1'b1, '1);
    fill(16'sh7FFF);
    step("ovf_pos", 1'b1, '1);
    fill(16'sh8000);
    step("ovf_neg", 1'b1, '1);
    idle(LEVELS);

    en_pat = 8'b1110_1101;
    for (int k = 1; k <= 8; k++) begin
      fill(WID'(k));
      step($sformatf("stream%0d", k), en_pat[k-1], '1);
    end
    idle(LEVELS + 1);

    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N_IN; i++) lanes[i] = WID'($urandom_range(0, 65535));
      step($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), $urandom);
    end
    idle(LEVELS);

    fill(16'sd5);
    for (int k = 0; k < 7; k++) step("pre_rst", 1'b1, '1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_out", adder_tree_out, '0);
    check("rst_async_vld", {{(WID-1){1'b0}}, adder_tree_valid}, '0);
    @(posedge clk);
    #1;
    check("rst_hold_out", adder_tree_out, '0);
    check("rst_hold_vld", {{(WID-1){1'b0}}, adder_tree_valid}, '0);
    @(negedge clk);
    adder_enable = 1'b0;
    mac_enable   = '0;
    rst          = 1'b0;
    prime("post_rst");
    idle(LEVELS + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_adder_tree.md
Name: mac_adder_tree

Overview:
- Pipelined signed adder tree that reduces N_IN per-convolver MAC results to one sum per cycle.
- Sits in a PE between the convolver bank and the feedback adder / non-linearity stage.
- Per-lane enable mask excludes unused convolvers.
- Fully pipelined: accepts a new input vector every cycle.

Parameters:
- N_IN, 32, number of input lanes (convolvers per PE); N_IN >= 2.
- WID, 16, width in bits of each input and of the output; two's complement.
- LEVELS, $clog2(N_IN), number of tree levels; derived, not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- output_mac  input  N_IN x WID (unpacked array, signed)  per-lane MAC results.
- mac_enable  input  N_IN  per-lane include mask; lane i contributes only when bit i = 1.
- adder_enable  input  1  input-valid qualifier for the current vector.
- adder_tree_out  output  WID (signed)  registered tree sum.
- adder_tree_valid  output  1  high when adder_tree_out holds the sum of an enabled vector.

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - Clears every pipeline register, adder_tree_out and adder_tree_valid to 0 immediately, regardless of clk.
  - On release, the pipeline restarts empty; no stale partial sums may emerge.
- Lane masking:
  - Stage-0 operand i = output_mac[i] when mac_enable[i] = 1 and adder_enable = 1; otherwise 0.
- Padding:
  - If N_IN is not a power of two, pad to 2^LEVELS lanes with constant-zero operands.
- Tree structure:
  - Binary tree of LEVELS levels.
  - Each level adds adjacent pairs: level k, node j = node 2j + node 2j+1 of level k-1.
  - Each level's result is registered.
- Internal width:
  - Level k carries WID + k bits, sign-extended, so no intermediate overflow is possible.
  - Final full-precision sum is WID + LEVELS bits.
- Output conversion:
  - Final sum is converted to WID bits (see Optional Feature) and presented directly from the last-level register.
  - No extra output register.
- Latency:
  - Exactly LEVELS clock edges from inputs sampled to adder_tree_out/adder_tree_valid updated; 5 cycles for N_IN = 32.
- Valid:
  - adder_enable is delayed through a LEVELS-deep shift register to form adder_tree_valid.
- Throughput:
  - Pipeline advances every cycle with no stall input.
  - When adder_enable = 0, zeros enter the tree: the corresponding output is 0 with valid = 0.
- Simultaneous events:
  - A lane change and a mask change in the same cycle use the values sampled at that edge.
  - Reset dominates any input activity.
- Signedness:
  - All arithmetic is two's complement.
  - Inputs are sign-extended, never zero-extended.

Optional Feature:
- Macro ADDER_TREE_SAT_EN.
- Defined: final sum saturates to the WID-bit signed range.
  - Above 2^(WID-1)-1 gives 2^(WID-1)-1.
  - Below -2^(WID-1) gives -2^(WID-1).
- Not defined: final sum is truncated to its low WID bits (wrap-around), matching the rest of the PE datapath.
- Latency is identical in both builds.

Test Plan:
- Reset: assert rst mid-stream with valid data in flight -> adder_tree_out = 0 and adder_tree_valid = 0 immediately. After release, 5 idle cycles -> output stays 0.
- Sum all: N_IN = 32, all lanes = 1, mac_enable = 32'hFFFF_FFFF, adder_enable = 1 for one cycle -> after 5 cycles out = 32, valid = 1 for exactly one cycle.
- Mask and sign:
  - lanes i = i+1, mac_enable = 32'h0000_0001 -> out = 1.
  - mac_enable = 32'h8000_0000 -> out = 32.
  - lanes alternating +100/-100 with all enabled -> out = 0.
  - all lanes = -3 -> out = -96.
- Overflow, all lanes 16'h7FFF, all enabled:
  - without ADDER_TREE_SAT_EN -> out = 16'hFFE0.
  - with the macro -> out = 16'h7FFF.
- Overflow, all lanes 16'h8000, all enabled:
  - without the macro -> out = 16'h0000.
  - with the macro -> out = 16'h8000.
- Streaming: 8 consecutive vectors with lanes all = 1..8 and adder_enable toggling 1,0,1,1,0,1,1,1 -> outputs 32,0,96,128,0,192,224,256, with valid pattern identical to adder_enable, delayed 5 cycles.
